// File: rtl/tl_tx_arb.sv
// Transaction-layer transmit arbiter: round-robin merge of completion and request
// TLP sources onto one link stream, gated by per-class header credits.
module tl_tx_arb #(
    parameter int unsigned CRED_W        = 8,
    parameter int unsigned CPL_CRED_INIT = 4,
    parameter int unsigned REQ_CRED_INIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [127:0] cpl_hdr_i,
    input  logic         cpl_has_data_i,
    input  logic         cpl_hdr_valid_i,
    output logic         cpl_hdr_ready_o,
    input  logic [255:0] cpl_data_i,
    input  logic         cpl_data_last_i,
    input  logic         cpl_data_valid_i,
    output logic         cpl_data_ready_o,

    input  logic [127:0] req_hdr_i,
    input  logic         req_has_data_i,
    input  logic         req_hdr_valid_i,
    output logic         req_hdr_ready_o,
    input  logic [255:0] req_data_i,
    input  logic         req_data_last_i,
    input  logic         req_data_valid_i,
    output logic         req_data_ready_o,

    input  logic         cpl_cred_ret_i,
    input  logic         req_cred_ret_i,

    output logic [255:0] tlp_data_o,
    output logic         tlp_sop_o,
    output logic         tlp_eop_o,
    output logic         tlp_valid_o,
    input  logic         tlp_ready_i
);

    localparam int unsigned HDR_W  = 128;
    localparam int unsigned DATA_W = 256;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [CRED_W-1:0] CRED_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic              gnt_cpl_q, gnt_cpl_d;
    logic              last_cpl_q, last_cpl_d;
    logic [CRED_W-1:0] cpl_cred_q, req_cred_q;
    logic              cpl_dec, req_dec;

    logic              cpl_elig, req_elig;
    logic [HDR_W-1:0]  hdr_sel;
    logic              has_sel;
    logic [DATA_W-1:0] data_sel;
    logic              dvalid_sel;
    logic              dlast_sel;

    assign cpl_elig   = cpl_hdr_valid_i && (cpl_cred_q != '0);
    assign req_elig   = req_hdr_valid_i && (req_cred_q != '0);

    // Granted-source view, held stable for the whole packet by gnt_cpl_q
    assign hdr_sel    = gnt_cpl_q ? cpl_hdr_i        : req_hdr_i;
    assign has_sel    = gnt_cpl_q ? cpl_has_data_i   : req_has_data_i;
    assign data_sel   = gnt_cpl_q ? cpl_data_i       : req_data_i;
    assign dvalid_sel = gnt_cpl_q ? cpl_data_valid_i : req_data_valid_i;
    assign dlast_sel  = gnt_cpl_q ? cpl_data_last_i  : req_data_last_i;

    // Return and consume in the same cycle cancel; returns saturate at the top
    function automatic logic [CRED_W-1:0] cred_next(input logic [CRED_W-1:0] cur,
                                                     input logic dec,
                                                     input logic ret);
        if (dec && !ret) begin
            return cur - CRED_W'(1);
        end
        if (ret && !dec && (cur != CRED_MAX)) begin
            return cur + CRED_W'(1);
        end
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_cpl_q  <= 1'b0;
            last_cpl_q <= 1'b0;
            cpl_cred_q <= CRED_W'(CPL_CRED_INIT);
            req_cred_q <= CRED_W'(REQ_CRED_INIT);
        end else begin
            state_q    <= state_d;
            gnt_cpl_q  <= gnt_cpl_d;
            last_cpl_q <= last_cpl_d;
            cpl_cred_q <= cred_next(cpl_cred_q, cpl_dec, cpl_cred_ret_i);
            req_cred_q <= cred_next(req_cred_q, req_dec, req_cred_ret_i);
        end
    end

    always_comb begin
        state_d          = state_q;
        gnt_cpl_d        = gnt_cpl_q;
        last_cpl_d       = last_cpl_q;
        cpl_dec          = 1'b0;
        req_dec          = 1'b0;
        cpl_hdr_ready_o  = 1'b0;
        cpl_data_ready_o = 1'b0;
        req_hdr_ready_o  = 1'b0;
        req_data_ready_o = 1'b0;
        tlp_data_o       = '0;
        tlp_sop_o        = 1'b0;
        tlp_eop_o        = 1'b0;
        tlp_valid_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpl_elig || req_elig) begin
                    gnt_cpl_d  = cpl_elig && (!req_elig || !last_cpl_q);
                    last_cpl_d = gnt_cpl_d;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                tlp_valid_o = 1'b1;
                tlp_sop_o   = 1'b1;
                tlp_eop_o   = !has_sel;
                tlp_data_o  = {{(DATA_W-HDR_W){1'b0}}, hdr_sel};
                if (gnt_cpl_q) begin
                    cpl_hdr_ready_o = tlp_ready_i;
                end else begin
                    req_hdr_ready_o = tlp_ready_i;
                end
                if (tlp_ready_i) begin
                    cpl_dec = gnt_cpl_q;
                    req_dec = !gnt_cpl_q;
                    state_d = has_sel ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                tlp_valid_o = dvalid_sel;
                if (dvalid_sel) begin
                    tlp_eop_o  = dlast_sel;
                    tlp_data_o = data_sel;
                end
                if (gnt_cpl_q) begin
                    cpl_data_ready_o = tlp_ready_i;
                end else begin
                    req_data_ready_o = tlp_ready_i;
                end
                if (dvalid_sel && tlp_ready_i && dlast_sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is offered to either side while reset is held
        if (!rst_n) begin
            cpl_hdr_ready_o  = 1'b0;
            cpl_data_ready_o = 1'b0;
            req_hdr_ready_o  = 1'b0;
            req_data_ready_o = 1'b0;
            tlp_data_o       = '0;
            tlp_sop_o        = 1'b0;
            tlp_eop_o        = 1'b0;
            tlp_valid_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_tl_tx_arb.sv
// Randomized bench for tl_tx_arb: packet-level sources and an expected-beat
// scoreboard driven by arbitration and credit rules.
module tb_tl_tx_arb;

    localparam int CPL_INIT = 4;
    localparam int REQ_INIT = 4;
    localparam int CRED_MAX = 255;

    typedef struct {
        logic [127:0] hdr;
        logic         has_data;
        int           nbeats;
        logic [255:0] data [4];
    } pkt_t;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic         is_hdr;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] hdr [2];
    logic         has [2];
    logic         hv  [2];
    logic [255:0] dat [2];
    logic         dl  [2];
    logic         dv  [2];
    logic         ret [2];
    logic         tlp_ready;

    logic         cpl_hdr_ready, cpl_data_ready, req_hdr_ready, req_data_ready;
    logic [255:0] tlp_data;
    logic         tlp_sop, tlp_eop, tlp_valid;

    always #5 clk = ~clk;

    tl_tx_arb #(.CRED_W(8), .CPL_CRED_INIT(CPL_INIT), .REQ_CRED_INIT(REQ_INIT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpl_hdr_i        (hdr[0]),
        .cpl_has_data_i   (has[0]),
        .cpl_hdr_valid_i  (hv[0]),
        .cpl_hdr_ready_o  (cpl_hdr_ready),
        .cpl_data_i       (dat[0]),
        .cpl_data_last_i  (dl[0]),
        .cpl_data_valid_i (dv[0]),
        .cpl_data_ready_o (cpl_data_ready),
        .req_hdr_i        (hdr[1]),
        .req_has_data_i   (has[1]),
        .req_hdr_valid_i  (hv[1]),
        .req_hdr_ready_o  (req_hdr_ready),
        .req_data_i       (dat[1]),
        .req_data_last_i  (dl[1]),
        .req_data_valid_i (dv[1]),
        .req_data_ready_o (req_data_ready),
        .cpl_cred_ret_i   (ret[0]),
        .req_cred_ret_i   (ret[1]),
        .tlp_data_o       (tlp_data),
        .tlp_sop_o        (tlp_sop),
        .tlp_eop_o        (tlp_eop),
        .tlp_valid_o      (tlp_valid),
        .tlp_ready_i      (tlp_ready)
    );

    int n_chk = 0;
    int n_pass = 0;

    // stimulus sources (index 0 = completion, 1 = request)
    pkt_t srcq [2][$];
    logic hdr_done [2];
    int   beat_idx [2];
    logic rst_req;
    logic force_ret [2];
    logic gen_on;
    int   gen_pct, p_ready, p_dval, p_ret;

    // reference model
    beat_t m_q [$];
    int    m_owner;
    int    m_cred [2];
    logic  m_last_cpl;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic pkt_t make_pkt(input logic has_d, input int nb);
        pkt_t p;
        p.hdr      = {$urandom(), $urandom(), $urandom(), $urandom()};
        p.has_data = has_d;
        p.nbeats   = has_d ? nb : 0;
        for (int i = 0; i < 4; i++)
            p.data[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
        return p;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_owner    = 0;
        m_cred[0]  = CPL_INIT;
        m_cred[1]  = REQ_INIT;
        m_last_cpl = 1'b0;
        for (int s = 0; s < 2; s++) begin
            srcq[s].delete();
            hdr_done[s] = 1'b0;
            beat_idx[s] = 0;
        end
    endtask

    task automatic drive();
        pkt_t pk;
        rst_n     = !rst_req;
        tlp_ready = (int'($urandom_range(99)) < p_ready);
        for (int s = 0; s < 2; s++) begin
            ret[s] = force_ret[s] || (int'($urandom_range(99)) < p_ret);
            if (srcq[s].size() > 0) begin
                pk     = srcq[s][0];
                hv[s]  = !hdr_done[s];
                hdr[s] = pk.hdr;
                has[s] = pk.has_data;
                dv[s]  = hdr_done[s] && pk.has_data && (int'($urandom_range(99)) < p_dval);
                dat[s] = pk.data[beat_idx[s]];
                dl[s]  = (beat_idx[s] == pk.nbeats - 1);
            end else begin
                hv[s] = 1'b0; hdr[s] = '0; has[s] = 1'b0;
                dv[s] = 1'b0; dat[s] = '0; dl[s] = 1'b0;
            end
        end
    endtask

    task automatic evaluate();
        logic  hr [2], dr [2], eh [2], ed [2], dec [2], elig [2];
        logic  exp_v;
        beat_t b;
        pkt_t  p;
        hr[0] = cpl_hdr_ready; dr[0] = cpl_data_ready;
        hr[1] = req_hdr_ready; dr[1] = req_data_ready;
        for (int s = 0; s < 2; s++) begin
            dec[s] = 1'b0; eh[s] = 1'b0; ed[s] = 1'b0;
        end
        if (!rst_n) begin
            check("rst_out", 256'({tlp_valid, tlp_sop, tlp_eop, hr[0], dr[0], hr[1], dr[1]}), 256'(0));
            check("rst_data", tlp_data, 256'(0));
            model_reset();
            return;
        end
        if (m_q.size() == 0) begin
            check("idle_out", 256'({tlp_valid, hr[0], dr[0], hr[1], dr[1]}), 256'(0));
            for (int s = 0; s < 2; s++) elig[s] = hv[s] && (m_cred[s] > 0);
            if (elig[0] || elig[1]) begin
                if (elig[0] && elig[1]) m_owner = m_last_cpl ? 1 : 0;
                else m_owner = elig[0] ? 0 : 1;
                m_last_cpl = (m_owner == 0);
                p = srcq[m_owner][0];
                b.data = {128'b0, p.hdr}; b.sop = 1'b1; b.eop = !p.has_data; b.is_hdr = 1'b1;
                m_q.push_back(b);
                for (int i = 0; i < p.nbeats; i++) begin
                    b.data = p.data[i]; b.sop = 1'b0; b.eop = (i == p.nbeats - 1); b.is_hdr = 1'b0;
                    m_q.push_back(b);
                end
            end
        end else begin
            b = m_q[0];
            eh[m_owner] = b.is_hdr ? tlp_ready : 1'b0;
            ed[m_owner] = b.is_hdr ? 1'b0 : tlp_ready;
            check("readies", 256'({hr[0], dr[0], hr[1], dr[1]}), 256'({eh[0], ed[0], eh[1], ed[1]}));
            exp_v = b.is_hdr ? 1'b1 : dv[m_owner];
            check("valid", 256'(tlp_valid), 256'(exp_v));
            if (exp_v) begin
                check("beat_data", tlp_data, b.data);
                check("beat_sop_eop", 256'({tlp_sop, tlp_eop}), 256'({b.sop, b.eop}));
                if (tlp_ready) begin
                    void'(m_q.pop_front());
                    if (b.is_hdr) dec[m_owner] = 1'b1;
                end
            end else begin
                check("idle_beat_zero", 256'({tlp_data, tlp_sop, tlp_eop}), 256'(0));
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (dec[s] && !ret[s]) m_cred[s] = m_cred[s] - 1;
            else if (ret[s] && !dec[s] && m_cred[s] < CRED_MAX) m_cred[s] = m_cred[s] + 1;
            if (srcq[s].size() > 0) begin
                if (hv[s] && hr[s]) begin
                    hdr_done[s] = 1'b1;
                    if (!srcq[s][0].has_data) begin
                        void'(srcq[s].pop_front());
                        hdr_done[s] = 1'b0;
                    end
                end else if (dv[s] && dr[s]) begin
                    if (dl[s]) begin
                        void'(srcq[s].pop_front());
                        hdr_done[s] = 1'b0;
                        beat_idx[s] = 0;
                    end else begin
                        beat_idx[s] = beat_idx[s] + 1;
                    end
                end
            end
            if (gen_on && srcq[s].size() < 3 && int'($urandom_range(99)) < gen_pct)
                srcq[s].push_back(make_pkt(1'($urandom_range(1)), int'($urandom_range(3, 1))));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        evaluate();
    endtask

    initial begin
        logic reached;
        rst_n = 1'b0; rst_req = 1'b1; tlp_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            force_ret[s] = 1'b0; ret[s] = 1'b0; hv[s] = 1'b0; dv[s] = 1'b0;
            hdr[s] = '0; has[s] = 1'b0; dat[s] = '0; dl[s] = 1'b0;
        end
        gen_on = 1'b0; gen_pct = 0; p_ready = 100; p_dval = 100; p_ret = 0;
        model_reset();
        repeat (3) step();
        rst_req = 1'b0;

        // simultaneous two-beat packets: CPL wins the first tie after reset
        srcq[0].push_back(make_pkt(1'b1, 2));
        srcq[1].push_back(make_pkt(1'b1, 2));
        repeat (12) step();

        // lone header-only completion
        srcq[0].push_back(make_pkt(1'b0, 0));
        repeat (4) step();

        // random traffic with backpressure, gaps and credit returns
        gen_on = 1'b1; gen_pct = 30; p_ready = 70; p_dval = 70; p_ret = 8;
        repeat (3000) step();

        gen_on = 1'b0; p_ready = 100; p_dval = 100; p_ret = 25;
        repeat (300) step();
        check("drained", 256'(srcq[0].size() + srcq[1].size() + m_q.size()), 256'(0));

        // saturate the completion counter, then consume all of it
        p_ret = 0; force_ret[0] = 1'b1;
        repeat (260) step();
        force_ret[0] = 1'b0;
        for (int i = 0; i < 257; i++) srcq[0].push_back(make_pkt(1'b0, 0));
        repeat (600) step();
        check("sat_pending", 256'(srcq[0].size()), 256'(2));

        p_ret = 25;
        repeat (100) step();

        // reset in the middle of a data phase
        p_ret = 0; p_dval = 0;
        srcq[0].push_back(make_pkt(1'b1, 3));
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            step();
            reached = (m_q.size() > 0) && !m_q[0].is_hdr;
        end
        check("reach_data", 256'(reached), 256'(1));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0; p_dval = 100;

        // init credits after reset; exhausted request class resumes on one return
        for (int i = 0; i < 5; i++) begin
            srcq[0].push_back(make_pkt(1'b0, 0));
            srcq[1].push_back(make_pkt(1'b0, 0));
        end
        repeat (30) step();
        check("req_blocked", 256'(srcq[1].size()), 256'(1));
        check("cpl_blocked", 256'(srcq[0].size()), 256'(1));
        force_ret[1] = 1'b1;
        step();
        force_ret[1] = 1'b0;
        repeat (6) step();
        check("req_after_ret", 256'(srcq[1].size()), 256'(0));
        check("cpl_still_blocked", 256'(srcq[0].size()), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tl_tx_arb.md
TL_TX_ARB -- requirements
Module: tl_tx_arb

Interface
REQ-001 Parameter: CRED_W, 8, width of each header-credit counter.
REQ-002 Parameter: CPL_CRED_INIT, 4, completion credit count loaded at reset.
REQ-003 Parameter: REQ_CRED_INIT, 4, request credit count loaded at reset.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cpl_hdr_i  in  128  completion header; cpl_has_data_i  in  1  1 = CplD, data beats follow.
REQ-007 cpl_hdr_valid_i  in  1; cpl_hdr_ready_o  out  1  completion header handshake.
REQ-008 cpl_data_i  in  256; cpl_data_last_i  in  1; cpl_data_valid_i  in  1; cpl_data_ready_o  out  1  completion payload beats.
REQ-009 req_hdr_i  in  128; req_has_data_i  in  1; req_hdr_valid_i  in  1; req_hdr_ready_o  out  1  outbound request header handshake.
REQ-010 req_data_i  in  256; req_data_last_i  in  1; req_data_valid_i  in  1; req_data_ready_o  out  1  request payload beats.
REQ-011 cpl_cred_ret_i  in  1; req_cred_ret_i  in  1  one-cycle pulse, returns one header credit to that class.
REQ-012 tlp_data_o  out  256; tlp_sop_o  out  1; tlp_eop_o  out  1; tlp_valid_o  out  1; tlp_ready_i  in  1  merged TLP stream to the link layer.

Function
REQ-013 Beat transfers on any channel only when valid and ready are both high in the same cycle.
REQ-014 FSM states: IDLE, HDR, DATA.
REQ-015 Eligibility: source eligible when its hdr_valid is high and its credit counter is nonzero.
REQ-016 IDLE: if any source is eligible, latch grant, go to HDR next cycle; no output valid in IDLE.
REQ-017 Arbitration: round-robin; with both eligible, grant the source not granted last; the last-grant pointer updates only on grant; after reset, CPL wins the first tie.
REQ-018 HDR: tlp_valid_o = 1, tlp_data_o = {128'b0, granted hdr}, tlp_sop_o = 1, tlp_eop_o = !granted has_data; granted hdr_ready_o = tlp_ready_i; the other source's ready stays 0.
REQ-019 Header handshake: decrement granted credit by 1; go to DATA if has_data, else IDLE.
REQ-020 DATA: tlp_valid_o = granted data_valid, tlp_data_o = granted data, tlp_sop_o = 0, tlp_eop_o = granted data_last; granted data_ready_o = tlp_ready_i.
REQ-021 DATA: handshake with last = 1 returns to IDLE; header-valid to first output latency is 1 cycle minimum.
REQ-022 Grant is held from IDLE exit until end of packet; no interleaving of sources within a TLP.
REQ-023 Ready outputs are 0 in IDLE and to the ungranted source in all states.
REQ-024 tlp_data_o, sop, eop are don't-care when tlp_valid_o = 0; driven 0.
REQ-025 Credit return with no simultaneous decrement: +1, saturating at 2^CRED_W-1.
REQ-026 Credit return coinciding with decrement of the same class: counter unchanged.
REQ-027 Counter at 0 blocks new grants of that class only; an in-flight packet always completes.
REQ-028 Backpressure (tlp_ready_i = 0) holds state, outputs, and counters except credit returns.

Reset
REQ-029 rst_n low at a clock edge: FSM to IDLE, grant cleared, round-robin pointer favouring CPL, cpl credit = CPL_CRED_INIT, req credit = REQ_CRED_INIT.
REQ-030 All ready and tlp outputs 0 during and the cycle after reset; reset mid-packet abandons the packet without emitting eop.

Verification
REQ-031 CPL hdr (has_data = 0) alone, tlp_ready_i = 1 -> one beat, sop = eop = 1, at cycle 1 after valid; cpl credit 4 -> 3.
REQ-032 Both valid with headers having data, 2 beats each -> CPL sop, 2 beats (eop on 2nd), then REQ packet; REQ data_ready 0 throughout CPL packet.
REQ-033 Req credit driven to 0 by 4 requests, then req valid -> no grant; one req_cred_ret_i pulse -> grant next IDLE cycle.
REQ-034 tlp_ready_i toggled 0/1 in DATA -> no beat dropped or duplicated; payload order preserved.
REQ-035 cpl_cred_ret_i pulsed on the same cycle as a CPL header handshake -> credit unchanged; pulse with counter at 255 -> remains 255.
REQ-036 rst_n asserted mid-DATA -> next cycle IDLE, credits at init values, all readies 0.
